// File: rtl/gray_code_counter_pkg.sv
// Shared definitions for the Gray code counter and its Gray-pointer helpers.
// Conversion functions work on a fixed wide vector: callers zero-extend a
// WIDTH-bit value in and truncate the result back to WIDTH bits. Zero upper
// bits are neutral for both conversions, so one function serves every width.
package gray_code_counter_pkg;

  // Widest code the helper functions handle.
  localparam int GCC_MAX_WIDTH = 32;

  // Width used when no parameter override is given.
  localparam int DEFAULT_WIDTH = 4;

  typedef logic [GCC_MAX_WIDTH-1:0] code_t;

  // Count direction as sampled from up_dn.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Operation selected on a clock edge, highest priority first: load, step, hold.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2
  } op_e;

  // Largest count value for a given width (2^width - 1).
  function automatic code_t max_val(input int width);
    return (code_t'(1) << width) - code_t'(1);
  endfunction

  // Terminal count of the default-width counter.
  localparam code_t MAX_VAL = max_val(DEFAULT_WIDTH);

  // Reflected binary to Gray code.
  function automatic code_t bin2gray(input code_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray code back to binary: each binary bit is the XOR of all Gray bits
  // at or above its position.
  function automatic code_t gray2bin(input code_t g);
    code_t b;
    b = '0;
    b[GCC_MAX_WIDTH-1] = g[GCC_MAX_WIDTH-1];
    for (int i = GCC_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Control and result bundle of the Gray code counter.
// master drives the controls and watches the counts; slave is the counter.
interface gray_code_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_gray,
    input  bin_out, gray_out, wrap
  );

  modport slave (
    input  en, up_dn, load, load_gray,
    output bin_out, gray_out, wrap
  );

endinterface

// File: rtl/gray_code_counter_gray_to_bin.sv
// Combinational WIDTH-bit Gray-to-binary decoder (the gray_to_bin block).
// Written as a flat XOR-reduction per bit rather than a ripple chain so each
// output bit is an independent cone; reusable wherever Gray pointers arrive.
module gray_code_counter_gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Binary bit gi is the parity of Gray bits WIDTH-1 down to gi.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter presenting its count in binary and Gray code,
// with a parallel load given in Gray code and a one-cycle wrap pulse.
// Optional build macro: GRAY_SATURATE_EN -- when defined the counter stops at
// its bounds instead of rolling over and wrap flags each blocked step.
module gray_code_counter
  import gray_code_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input logic              clk,
  input logic              rst,
  gray_code_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(code_t'(RST_BIN)));

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] gray_reg;
  logic             wrap_reg;

  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] stepped_gray;
  logic             at_bound;
  dir_e             dir;
  op_e              op;

  // Load path decodes the incoming Gray value to binary.
  gray_code_counter_gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_load_decode (
    .gray (bus.load_gray),
    .bin  (load_bin)
  );

  // Decode the per-edge operation (load beats count) and the step target.
  always_comb begin
    op = OP_HOLD;
    if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.en) begin
      op = OP_STEP;
    end
    dir = dir_e'(bus.up_dn);
    if (dir == DIR_UP) begin
      stepped  = bin_reg + WIDTH'(1);
      at_bound = (bin_reg == CNT_MAX);
    end else begin
      stepped  = bin_reg - WIDTH'(1);
      at_bound = (bin_reg == '0);
    end
    stepped_gray = WIDTH'(bin2gray(code_t'(stepped)));
  end

  // Next-state selection; the Gray value always tracks the new binary value.
  always_comb begin
    bin_next  = bin_reg;
    gray_next = gray_reg;
    wrap_next = 1'b0;
    case (op)
      OP_LOAD: begin
        bin_next  = load_bin;
        gray_next = bus.load_gray;
      end
      OP_STEP: begin
`ifdef GRAY_SATURATE_EN
        // Blocked at a bound: hold the count and flag the attempt.
        if (!at_bound) begin
          bin_next  = stepped;
          gray_next = stepped_gray;
        end
        wrap_next = at_bound;
`else
        // Modulo arithmetic rolls over; the bound test marks the rollover.
        bin_next  = stepped;
        gray_next = stepped_gray;
        wrap_next = at_bound;
`endif
      end
      default: begin
      end
    endcase
  end

  // State registers with asynchronous reset to the configured start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg  <= RST_BIN;
      gray_reg <= RST_GRAY;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bus.bin_out  = bin_reg;
  assign bus.gray_out = gray_reg;
  assign bus.wrap     = wrap_reg;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed self-checking bench for gray_code_counter (WIDTH=4, RESET_VAL=0).
// Saturating behaviour is exercised when GRAY_SATURATE_EN is defined.
module tb_gray_code_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};
  logic [3:0] prev_gray;

  gray_code_counter_if #(.WIDTH(4)) bus ();

  gray_code_counter #(
    .WIDTH     (4),
    .RESET_VAL (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, summary not printed");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: compare all three outputs and log one line.
  task automatic check_out(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                           input logic ew);
    $display("t=%0t %s bin=%b gray=%b wrap=%b", $time, tag, bus.bin_out, bus.gray_out, bus.wrap);
    check({tag, ".bin"}, 32'(bus.bin_out), 32'(eb));
    check({tag, ".gray"}, 32'(bus.gray_out), 32'(eg));
    check({tag, ".wrap"}, 32'(bus.wrap), 32'(ew));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.up_dn     = 1'b1;
    bus.load      = 1'b0;
    bus.load_gray = 4'b0000;

    // Reset state.
    #12;
    check_out("reset", 4'd0, 4'b0000, 1'b0);
    rst = 1'b0;

    // Count up to 7, then reset asynchronously mid-count.
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_out("count7", 4'd7, 4'b0100, 1'b0);
    rst = 1'b1;
    #1;
    check_out("async_rst", 4'd0, 4'b0000, 1'b0);
    tick();
    check_out("rst_held", 4'd0, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    check_out("restart1", 4'd1, 4'b0001, 1'b0);
    tick();
    check_out("restart2", 4'd2, 4'b0011, 1'b0);

    // Back to 0 by load, then a full up cycle with rollover.
    bus.en        = 1'b0;
    bus.load      = 1'b1;
    bus.load_gray = 4'b0000;
    tick();
    check_out("load0", 4'd0, 4'b0000, 1'b0);
    bus.load  = 1'b0;
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
    prev_gray = bus.gray_out;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_out($sformatf("up%0d", k), 4'(k), gtab[4'(k)], (k == 16));
      check($sformatf("onebit%0d", k), 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
      prev_gray = bus.gray_out;
    end

    // Count down through 0.
    bus.up_dn = 1'b0;
    tick();
    check_out("down_wrap", 4'd15, 4'b1000, 1'b1);
    check("down_onebit", 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
    tick();
    check_out("down14", 4'd14, 4'b1001, 1'b0);
    bus.en = 1'b0;
    tick();
    check_out("hold14", 4'd14, 4'b1001, 1'b0);

    // Load wins over a simultaneous enable.
    bus.load      = 1'b1;
    bus.load_gray = 4'b0110;
    bus.en        = 1'b1;
    bus.up_dn     = 1'b1;
    tick();
    check_out("load_vs_en", 4'd4, 4'b0110, 1'b0);

    // Load 5 (Gray 0111), then toggle direction each cycle.
    bus.load_gray = 4'b0111;
    bus.en        = 1'b0;
    tick();
    check_out("load5", 4'd5, 4'b0111, 1'b0);
    bus.load  = 1'b0;
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
    tick();
    check_out("tog6a", 4'd6, 4'b0101, 1'b0);
    bus.up_dn = 1'b0;
    tick();
    check_out("tog5a", 4'd5, 4'b0111, 1'b0);
    bus.up_dn = 1'b1;
    tick();
    check_out("tog6b", 4'd6, 4'b0101, 1'b0);
    bus.up_dn = 1'b0;
    tick();
    check_out("tog5b", 4'd5, 4'b0111, 1'b0);

    // Disabled: direction changes have no effect.
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.up_dn = ~bus.up_dn;
      tick();
      check_out($sformatf("idle%0d", i), 4'd5, 4'b0111, 1'b0);
    end

    // Load the top value (Gray 1000) and step up from it.
    bus.load      = 1'b1;
    bus.load_gray = 4'b1000;
    tick();
    check_out("load15", 4'd15, 4'b1000, 1'b0);
    bus.load  = 1'b0;
    bus.en    = 1'b1;
    bus.up_dn = 1'b1;
`ifdef GRAY_SATURATE_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("sat_hi%0d", i), 4'd15, 4'b1000, 1'b1);
    end
    bus.up_dn = 1'b0;
    tick();
    check_out("sat_leave", 4'd14, 4'b1001, 1'b0);
    bus.load      = 1'b1;
    bus.load_gray = 4'b0000;
    tick();
    check_out("sat_load0", 4'd0, 4'b0000, 1'b0);
    bus.load = 1'b0;
    tick();
    check_out("sat_lo", 4'd0, 4'b0000, 1'b1);
`else
    tick();
    check_out("up_wrap", 4'd0, 4'b0000, 1'b1);
    tick();
    check_out("after_wrap", 4'd1, 4'b0001, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
